// File: rtl/mips_mem_pkg.sv
// Shared definitions for the unified-memory port arbiter of the multicycle MIPS core.
// Contents: arbiter state encoding, requester (owner) encoding and word geometry.
package mips_mem_pkg;

    // Arbiter sequencing: pick a winner, drive the memory, return the result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Which requester owns the access in flight.
    typedef enum logic {
        INSTR = 1'b0,
        DATA  = 1'b1
    } owner_e;

    localparam int WORD_BYTES    = 4;
    localparam int BYTE_OFS_BITS = $clog2(WORD_BYTES);

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker (purely combinational).
// Ports:
//   req   [1:0] : request vector, bit 0 = instruction fetch, bit 1 = data
//   last        : owner of the previous grant; loses a tie
//   grant [1:0] : one-hot grant, all zero when nobody asks
module rr_arb2
    import mips_mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output logic [1:0] grant
);

    // Lone requester wins; on a tie the port that did not win last time goes first.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last == INSTR) ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified instruction/data memory between the fetch port
// and the load/store port. One access at a time: the winning request is latched
// in IDLE, the memory is driven from registers during SERVE, and the captured
// read data is returned with a one-cycle acknowledge in RESP.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   i_req/i_addr                : fetch request (read-only)
//   i_ack/i_rdata/i_err         : fetch completion, data, error flag
//   d_req/d_we/d_addr/d_wdata   : load/store request
//   d_ack/d_rdata/d_err         : data completion, load data (0 for stores), error
//   mem_addr/mem_wdata          : registered memory address / write data
//   mem_read/mem_write          : registered memory strobes
//   mem_rdata                   : combinational memory read data
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int DEPTH_WORDS = 128
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic             i_ack,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_ack,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_err,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_read,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [WIDTH-BYTE_OFS_BITS-1:0] DEPTH_LIM = (WIDTH-BYTE_OFS_BITS)'(DEPTH_WORDS);

    state_e           state_r, state_s;
    owner_e           owner_r, rr_last_r, sel_owner_s;
    logic [1:0]       req_s, grant_s;
    logic [WIDTH-1:0] addr_r, wdata_r, sel_addr_s, sel_wdata_s, result_s;
    logic             sel_we_s, sel_err_s, err_r;
    logic             mem_read_r, mem_write_r;
    logic             i_ack_r, d_ack_r, i_err_r, d_err_r;
    logic [WIDTH-1:0] i_rdata_r, d_rdata_r;

    assign req_s = {d_req, i_req};

    rr_arb2 u_rr_arb2 (
        .req   (req_s),
        .last  (rr_last_r),
        .grant (grant_s)
    );

    // Mux the granted request's fields and classify its address.
    always_comb begin
        sel_owner_s = INSTR;
        sel_addr_s  = i_addr;
        sel_wdata_s = {WIDTH{1'b0}};
        sel_we_s    = 1'b0;
        if (grant_s[1]) begin
            sel_owner_s = DATA;
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
            sel_we_s    = d_we;
        end else begin
            sel_owner_s = INSTR;
            sel_addr_s  = i_addr;
            sel_wdata_s = {WIDTH{1'b0}};
            sel_we_s    = 1'b0;
        end
        sel_err_s = (sel_addr_s[BYTE_OFS_BITS-1:0] != {BYTE_OFS_BITS{1'b0}}) ||
                    (sel_addr_s[WIDTH-1:BYTE_OFS_BITS] >= DEPTH_LIM);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: IDLE waits for a request, SERVE and RESP last one cycle each.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req_s) begin
                    state_s = SERVE;
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE:   state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Latch the winner in IDLE; strobes are armed for exactly the SERVE cycle.
    // Reset clears the strobes asynchronously, which cancels a write in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r     <= INSTR;
            rr_last_r   <= INSTR;
            addr_r      <= {WIDTH{1'b0}};
            wdata_r     <= {WIDTH{1'b0}};
            err_r       <= 1'b0;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end else if ((state_r == IDLE) && (|grant_s)) begin
            owner_r     <= sel_owner_s;
            rr_last_r   <= sel_owner_s;
            addr_r      <= sel_addr_s;
            wdata_r     <= sel_wdata_s;
            err_r       <= sel_err_s;
            mem_read_r  <= !sel_err_s && !sel_we_s;
            mem_write_r <= !sel_err_s && sel_we_s;
        end else begin
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
        end
    end

    // Stores and error accesses return zero data.
    assign result_s = mem_read_r ? mem_rdata : {WIDTH{1'b0}};

    // Capture the result at the end of SERVE; rdata/err hold until the owner's next access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_ack_r   <= 1'b0;
            d_ack_r   <= 1'b0;
            i_err_r   <= 1'b0;
            d_err_r   <= 1'b0;
            i_rdata_r <= {WIDTH{1'b0}};
            d_rdata_r <= {WIDTH{1'b0}};
        end else begin
            i_ack_r <= 1'b0;
            d_ack_r <= 1'b0;
            if (state_r == SERVE) begin
                if (owner_r == INSTR) begin
                    i_ack_r   <= 1'b1;
                    i_rdata_r <= result_s;
                    i_err_r   <= err_r;
                end else begin
                    d_ack_r   <= 1'b1;
                    d_rdata_r <= result_s;
                    d_err_r   <= err_r;
                end
            end
        end
    end

    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign mem_read  = mem_read_r;
    assign mem_write = mem_write_r;
    assign i_ack     = i_ack_r;
    assign i_rdata   = i_rdata_r;
    assign i_err     = i_err_r;
    assign d_ack     = d_ack_r;
    assign d_rdata   = d_rdata_r;
    assign d_err     = d_err_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences (contention, reset mid-write, stale request) and a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int WIDTH       = 32;
    localparam int DEPTH_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_n;
    logic        i_req, i_ack, i_err;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_ack, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] tb_mem  [0:127];
    logic [31:0] ref_mem [0:127];

    mem_port_arbiter #(.WIDTH(WIDTH), .DEPTH_WORDS(DEPTH_WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
        .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int k);
        if (k == 64) return 32'h8C01_0004;
        if (k == 4)  return 32'h0000_1234;
        return 32'hA500_0000 | 32'(k);
    endfunction

    // Memory: combinational read, write on the clock edge ending a mem_write cycle.
    assign mem_rdata = tb_mem[mem_addr[8:2]];
    always @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int k = 0; k < 128; k++) tb_mem[k] <= init_val(k);
        end else if (mem_write) begin
            tb_mem[mem_addr[8:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " i_ack"}, 32'(i_ack), 32'd0);
        chk({tag, " d_ack"}, 32'(d_ack), 32'd0);
        chk({tag, " i_err"}, 32'(i_err), 32'd0);
        chk({tag, " d_err"}, 32'(d_err), 32'd0);
        chk({tag, " i_rdata"}, i_rdata, 32'd0);
        chk({tag, " d_rdata"}, d_rdata, 32'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, " mem_read"}, 32'(mem_read), 32'd0);
        chk({tag, " mem_write"}, 32'(mem_write), 32'd0);
    endtask

    function automatic logic addr_is_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH_WORDS));
    endfunction

    // Single-requester transaction; caller is at a negedge with the arbiter idle.
    task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input string nm);
        int   cyc    = 0;
        int   reads  = 0;
        int   writes = 0;
        logic got    = 1'b0;
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        while (!got && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (mem_read) begin
                reads++;
                chk({nm, " mem_addr"}, mem_addr, addr);
            end
            if (mem_write) begin
                writes++;
                chk({nm, " wr mem_addr"}, mem_addr, addr);
                chk({nm, " mem_wdata"}, mem_wdata, wdata);
            end
            chk({nm, " foreign ack"}, 32'(port ? i_ack : d_ack), 32'd0);
            got = port ? d_ack : i_ack;
        end
        chk({nm, " ack seen"}, 32'(got), 32'd1);
        chk({nm, " latency"}, 32'(cyc), 32'd2);
        chk({nm, " reads"}, 32'(reads), 32'((!we && !exp_err) ? 1 : 0));
        chk({nm, " writes"}, 32'(writes), 32'((we && !exp_err) ? 1 : 0));
        chk({nm, " rdata"}, port ? d_rdata : i_rdata, exp_rdata);
        chk({nm, " err"}, 32'(port ? d_err : i_err), 32'(exp_err));
        if (we && !exp_err) ref_mem[addr[8:2]] = wdata;
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        port;   // 0 = fetch, 1 = data
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 19));
        if (r == 0) return ($urandom_range(0, 127) * 4) + $urandom_range(1, 3);
        if (r == 1) return ($urandom_range(128, 143) * 4);
        return $urandom_range(0, 127) * 4;
    endfunction

    initial begin
        vec_t        vecs [9];
        logic        own_q [$];
        int          cyc_q [$];
        int          acks, reads, rd_cyc;
        logic [31:0] rd_addr2;
        int          e, g_edge, free_edge;
        logic        last_data, g_own, g_err, g_we, w;
        logic [31:0] g_addr, g_data;

        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,         32'h8C01_0004, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h008, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h008, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h006, 32'h0,         32'h0,         1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'h200, 32'h0,         32'h0,         1'b1};
        vecs[5] = '{1'b1, 1'b1, 32'h1FC, 32'h1234_5678, 32'h0,         1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h1FC, 32'h0,         32'h1234_5678, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 32'h1FE, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[8] = '{1'b1, 1'b0, 32'h1FC, 32'h0,         32'h1234_5678, 1'b0};

        for (int k = 0; k < 128; k++) ref_mem[k] = init_val(k);

        // Reset, with both requesters already asking for the contention test.
        init_n = 1'b0; rst_n = 1'b0;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_wdata = 32'h0;
        #12 init_n = 1'b1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Contention: data wins first, then strict alternation every 3 cycles.
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (i_ack && d_ack) chk("contention double ack", 32'd1, 32'd0);
            if (d_ack) begin own_q.push_back(1'b1); cyc_q.push_back(c); end
            if (i_ack) begin own_q.push_back(1'b0); cyc_q.push_back(c); end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("contention ack count", 32'(own_q.size()), 32'd4);
        for (int k = 0; k < own_q.size() && k < 4; k++) begin
            chk($sformatf("contention owner %0d", k), 32'(own_q[k]), 32'((k % 2 == 0) ? 1 : 0));
            chk($sformatf("contention cycle %0d", k), 32'(cyc_q[k]), 32'(2 + 3 * k));
        end

        // Directed vector table.
        for (int k = 0; k < 9; k++) begin
            do_txn(vecs[k].port, vecs[k].we, vecs[k].addr, vecs[k].wdata,
                   vecs[k].exp_rdata, vecs[k].exp_err, $sformatf("vec%0d", k));
        end

        // Reset during SERVE of a store: write cancelled, no ack.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #2;
        chk("midreset mem_write before", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        d_req = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midreset no d_ack", 32'(d_ack), 32'd0);
        end
        chk("midreset word4 unchanged", tb_mem[4], 32'h0000_1234);
        rst_n = 1'b1;
        do_txn(1'b1, 1'b0, 32'h10, 32'h0, 32'h0000_1234, 1'b0, "postreset load");

        // Stale request: req held through RESP with a new address.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        acks = 0; reads = 0; rd_cyc = 0; rd_addr2 = 32'h0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (mem_read) begin
                reads++;
                if (reads == 2) begin rd_cyc = c; rd_addr2 = mem_addr; end
            end
            if (d_ack) begin
                acks++;
                if (acks == 1) begin
                    chk("stale first rdata", d_rdata, ref_mem[8]);
                    d_addr = 32'h24;
                end else begin
                    chk("stale second rdata", d_rdata, ref_mem[9]);
                    d_req = 1'b0;
                end
            end
        end
        d_req = 1'b0;
        chk("stale ack count", 32'(acks), 32'd2);
        chk("stale read count", 32'(reads), 32'd2);
        chk("stale second addr", rd_addr2, 32'h24);
        chk("stale second cycle", 32'(rd_cyc), 32'd4);

        // Randomized run against the transaction-level model.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rand reset");
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = rand_addr();
        d_req = 1'b1; d_we = 1'($urandom % 2); d_addr = rand_addr(); d_wdata = $urandom;
        e = 0; g_edge = -10; free_edge = 0; last_data = 1'b0;
        g_own = 1'b0; g_err = 1'b0; g_we = 1'b0; g_addr = 32'h0; g_data = 32'h0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            e++;
            // Arbiter takes a new request only once the previous 3-cycle access is done.
            if (e >= free_edge && (i_req || d_req)) begin
                w       = (i_req && d_req) ? !last_data : d_req;
                g_own   = w;
                g_addr  = w ? d_addr : i_addr;
                g_we    = w ? d_we : 1'b0;
                g_err   = addr_is_err(g_addr);
                g_data  = 32'h0;
                if (!g_err && g_we) ref_mem[g_addr[8:2]] = d_wdata;
                if (!g_err && !g_we) g_data = ref_mem[g_addr[8:2]];
                last_data = w;
                g_edge    = e;
                free_edge = e + 3;
            end
            @(negedge clk);
            chk("rand mem_read", 32'(mem_read), 32'((e == g_edge) && !g_err && !g_we));
            chk("rand mem_write", 32'(mem_write), 32'((e == g_edge) && !g_err && g_we));
            if (e == g_edge && !g_err) chk("rand mem_addr", mem_addr, g_addr);
            chk("rand i_ack", 32'(i_ack), 32'((e == g_edge + 1) && !g_own));
            chk("rand d_ack", 32'(d_ack), 32'((e == g_edge + 1) && g_own));
            if (e == g_edge + 1) begin
                chk("rand rdata", g_own ? d_rdata : i_rdata, g_data);
                chk("rand err", 32'(g_own ? d_err : i_err), 32'(g_err));
            end
            // Requester behaviour.
            if (e == g_edge) begin
                // Inputs of the granted port may change freely once latched.
                if (g_own) begin d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom % 2); end
                else       begin i_addr = $urandom; end
            end else if (e == g_edge + 1) begin
                if ($urandom % 2 == 0) begin
                    if (g_own) d_req = 1'b0; else i_req = 1'b0;
                end else if (g_own) begin
                    d_addr = rand_addr(); d_we = 1'($urandom % 2); d_wdata = $urandom;
                end else begin
                    i_addr = rand_addr();
                end
            end
            if (!i_req && !(e == g_edge + 1 && !g_own) && ($urandom % 3 == 0)) begin
                i_req = 1'b1; i_addr = rand_addr();
            end
            if (!d_req && !(e == g_edge + 1 && g_own) && ($urandom % 3 == 0)) begin
                d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom % 2); d_wdata = $urandom;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multicycle MIPS core between two requesters:
  - the instruction-fetch port (read-only);
  - the load/store data port (read/write).
- Grants one access at a time, latches the winning request and drives the memory's address, write data, read strobe and write strobe from registers.
- Captures the memory's combinational read data and returns it with a one-cycle acknowledge.
- Sits between the core's control FSM and the memory; replaces direct wiring of the memory address mux.

Parameters:
- WIDTH, 32, data and address width in bits.
- DEPTH_WORDS, 128, number of memory words; byte addresses at or beyond DEPTH_WORDS*4 are errors.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held high until i_ack is seen.
- i_addr  in  WIDTH  fetch byte address.
- i_ack  out  1  one-cycle pulse: fetch complete.
- i_rdata  out  WIDTH  fetched word; valid while i_ack=1.
- i_err  out  1  with i_ack: misaligned or out-of-range address.
- d_req  in  1  data request; held high until d_ack is seen.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  WIDTH  data byte address.
- d_wdata  in  WIDTH  store data.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  WIDTH  load data; valid while d_ack=1; 0 for stores.
- d_err  out  1  with d_ack: misaligned or out-of-range address.
- mem_addr  out  WIDTH  byte address to memory.
- mem_wdata  out  WIDTH  write data to memory.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable; the memory writes on the clk edge ending the cycle.
- mem_rdata  in  WIDTH  combinational read data from memory.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rr_last=INSTR, so data wins the first tie.
  - All outputs 0: acks, errs, rdata, mem_* outputs.
- States: IDLE, SERVE, RESP.
- IDLE:
  - If any request is pending, pick a winner:
    - if only one requester is asking, it wins;
    - if both are asking, the one not named in rr_last wins.
  - Latch the winner's owner, addr, we (0 for fetch) and wdata.
  - Latch the error flag: err = (addr[1:0]!=0) or (addr[WIDTH-1:2] >= DEPTH_WORDS).
  - Go to SERVE. Update rr_last to the winner.
  - If no request is pending, stay in IDLE.
- SERVE (exactly 1 cycle):
  - mem_addr = latched addr.
  - mem_read = !err & !we.
  - mem_write = !err & we.
  - mem_wdata = latched wdata.
  - At the cycle's end, capture the result: mem_rdata when mem_read=1, else 0.
  - Go to RESP.
- RESP (1 cycle):
  - Assert the owner's ack with rdata and err. The other port's ack stays 0.
  - mem_read and mem_write are 0.
  - Go to IDLE.
- Latency and throughput:
  - Request high at edge N → memory driven in cycle N+1 → ack high in cycle N+2.
  - Minimum 3 cycles per access.
- Handshake rules:
  - Requester drops req in the cycle after ack, or keeps it high to request again.
  - A req still high in RESP is ignored, since the arbiter is not in IDLE.
  - req, addr, we and wdata changing after the grant edge have no effect; the request was latched.
- Fairness:
  - With both requesters held high continuously, grants alternate D,I,D,I.
  - No port waits more than one foreign access.
- Timing structure:
  - All mem_* outputs come from registers or the state decode only.
  - No combinational path from i_/d_ inputs to mem_* outputs.
- Error accesses:
  - Never assert mem_read or mem_write.
  - rdata=0, err=1; arbitration still rotates.
- rdata outputs hold their value after ack; only the ack qualifies them.
- Reset asserted in SERVE:
  - mem_write drops asynchronously, so the write is cancelled.
  - No ack is produced.

Decomposition:
- Shared package mips_mem_pkg:
  - state encoding (IDLE/SERVE/RESP);
  - owner encoding (INSTR/DATA);
  - WORD_BYTES=4.
- One sub-module rr_arb2: a two-input round-robin picker.
  - Inputs: req[1:0] and last.
  - Output: one-hot grant.
  - Purely combinational.

Test Plan:
- Fetch only: after reset, i_req=1, i_addr=0x100, mem word 64=0x8C010004 → mem_read=1 with mem_addr=0x100 in cycle 1; i_ack=1, i_rdata=0x8C010004, i_err=0 in cycle 2; d_ack stays 0.
- Store then load: d_req with d_we=1, d_addr=0x8, d_wdata=0xDEADBEEF → mem_write=1 for exactly one cycle, d_ack with d_rdata=0. Then d_we=0 at 0x8 → d_rdata=0xDEADBEEF.
- Contention: i_req and d_req both held high from reset for 12 cycles → grant order D,I,D,I; 4 acks total, each 3 cycles apart.
- Errors: d_addr=0x6 (misaligned), then i_addr=0x200 (word 128 ≥ DEPTH) → no mem_read/mem_write ever high; ack with err=1 and rdata=0 for each.
- Reset mid-access: d_req store at 0x10, rst_n low during SERVE → mem_write falls immediately, word 4 unchanged, no d_ack; after release the state is IDLE and the next request is served normally.
- Stale request: requester holds d_req high through RESP with a new d_addr → the next access starts at the following IDLE edge using the new address; the old access is not repeated twice.
